// File: rtl/c4_pkg.sv
`default_nettype none
// =============================================================================
// Module   : c4_pkg
// Purpose  : Shared connect4 board constants, sequencer FSM states and the
//            per-move result record.
// Revision : 1.0 - initial release
// =============================================================================
package c4_pkg;

    localparam int          C4_COLS        = 7;
    localparam int          C4_ROWS        = 6;
    localparam int          C4_CELLS       = C4_COLS * C4_ROWS;
    localparam logic [2:0]  C4_COL_ILLEGAL = 3'd7;
    localparam int          C4_MIDX_W      = $clog2(C4_CELLS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RE = 2'd2,
        S_REPORT  = 2'd3
    } c4_state_t;

    typedef struct packed {
        logic                 player;
        logic [2:0]           col;
        logic [C4_MIDX_W-1:0] move_idx;
        logic                 err;
        logic                 finished;
        logic                 winner;
        logic                 tie;
    } c4_result_t;

endpackage
`default_nettype wire

// File: rtl/c4_move_fifo.sv
`default_nettype none
// =============================================================================
// Module   : c4_move_fifo
// Purpose  : Synchronous show-ahead FIFO with count-based full/empty flags.
// Revision : 1.0 - initial release
// =============================================================================
module c4_move_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_count == C_FULL_COUNT);
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/c4_move_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : c4_move_sequencer
// Purpose  : Buffers column-only moves, assigns alternating player IDs, drives
//            the engine op/re handshakes and emits one result record per move.
//            Optional: define C4_SEQ_STATS_EN to build the st_* game counters.
// Revision : 1.0 - initial release
// =============================================================================
module c4_move_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mv_valid,
    output logic       mv_ready,
    input  logic [2:0] mv_col,
    input  logic       op_ready,
    output logic       op_valid,
    output logic       op_player_id,
    output logic [2:0] op_col_id,
    output logic       re_ready,
    input  logic       re_valid,
    input  logic       re_err,
    input  logic       re_is_finished,
    input  logic       re_winner,
    input  logic       re_tie,
    input  logic       rs_ready,
    output logic       rs_valid,
    output logic       rs_player,
    output logic [2:0] rs_col,
    output logic [5:0] rs_move_idx,
    output logic       rs_err,
    output logic       rs_finished,
    output logic       rs_winner,
    output logic       rs_tie,
    output logic [7:0] st_games,
    output logic [7:0] st_wins0,
    output logic [7:0] st_wins1,
    output logic [7:0] st_ties
);

    import c4_pkg::*;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic [2:0]           w_head;

    c4_state_t            r_state;
    logic                 r_cur_player;
    logic [C4_MIDX_W-1:0] r_move_idx;
    logic [2:0]           r_col;
    logic                 r_op_valid;
    logic                 r_op_player;
    logic                 r_re_ready;
    logic                 r_rs_valid;
    c4_result_t           r_rs;

    c4_move_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (3)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mv_valid),
        .din   (mv_col),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_pop        = (r_state == S_IDLE) & ~w_fifo_empty;
    assign mv_ready     = ~w_fifo_full;

    assign op_valid     = r_op_valid;
    assign op_player_id = r_op_player;
    assign op_col_id    = r_col;
    assign re_ready     = r_re_ready;

    assign rs_valid     = r_rs_valid;
    assign rs_player    = r_rs.player;
    assign rs_col       = r_rs.col;
    assign rs_move_idx  = r_rs.move_idx;
    assign rs_err       = r_rs.err;
    assign rs_finished  = r_rs.finished;
    assign rs_winner    = r_rs.winner;
    assign rs_tie       = r_rs.tie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur_player <= 1'b0;
            r_move_idx   <= '0;
            r_col        <= '0;
            r_op_valid   <= 1'b0;
            r_op_player  <= 1'b0;
            r_re_ready   <= 1'b0;
            r_rs_valid   <= 1'b0;
            r_rs         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        // Issue-time identity is latched here so the record
                        // reflects who moved, whatever happens afterwards.
                        r_col           <= w_head;
                        r_rs.player     <= r_cur_player;
                        r_rs.col        <= w_head;
                        r_rs.move_idx   <= r_move_idx;
                        r_rs.finished   <= 1'b0;
                        r_rs.winner     <= 1'b0;
                        r_rs.tie        <= 1'b0;
                        if (w_head == C4_COL_ILLEGAL) begin
                            r_rs.err    <= 1'b1;
                            r_rs_valid  <= 1'b1;
                            r_state     <= S_REPORT;
                        end else begin
                            r_rs.err    <= 1'b0;
                            r_op_valid  <= 1'b1;
                            r_op_player <= r_cur_player;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        r_op_valid <= 1'b0;
                        r_re_ready <= 1'b1;
                        r_state    <= S_WAIT_RE;
                    end
                end
                S_WAIT_RE: begin
                    if (re_valid) begin
                        r_rs.err      <= re_err;
                        r_rs.finished <= re_is_finished;
                        r_rs.winner   <= re_winner;
                        r_rs.tie      <= re_tie;
                        r_re_ready    <= 1'b0;
                        r_rs_valid    <= 1'b1;
                        r_state       <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (rs_ready) begin
                        r_rs_valid <= 1'b0;
                        r_state    <= S_IDLE;
                        // A rejected move leaves the turn with the same player.
                        if (r_rs.err) begin
                            r_cur_player <= r_cur_player;
                        end else if (r_rs.finished) begin
                            r_cur_player <= 1'b0;
                            r_move_idx   <= '0;
                        end else begin
                            r_cur_player <= ~r_cur_player;
                            r_move_idx   <= r_move_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef C4_SEQ_STATS_EN
    logic       w_game_end;
    logic [7:0] r_st_games;
    logic [7:0] r_st_wins0;
    logic [7:0] r_st_wins1;
    logic [7:0] r_st_ties;

    assign w_game_end = (r_state == S_REPORT) & rs_ready & ~r_rs.err & r_rs.finished;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_games <= '0;
            r_st_wins0 <= '0;
            r_st_wins1 <= '0;
            r_st_ties  <= '0;
        end else if (w_game_end) begin
            r_st_games <= r_st_games + 1'b1;
            if (r_rs.tie)         r_st_ties  <= r_st_ties + 1'b1;
            else if (r_rs.winner) r_st_wins1 <= r_st_wins1 + 1'b1;
            else                  r_st_wins0 <= r_st_wins0 + 1'b1;
        end
    end

    assign st_games = r_st_games;
    assign st_wins0 = r_st_wins0;
    assign st_wins1 = r_st_wins1;
    assign st_ties  = r_st_ties;
`else
    assign st_games = '0;
    assign st_wins0 = '0;
    assign st_wins1 = '0;
    assign st_ties  = '0;
`endif

endmodule
`default_nettype wire
